// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl -- issue/hazard control for the decode->execute boundary.
//
// Resolves three kinds of pipeline events, highest priority first:
//   * branch flush (taken conditional branch or unconditional branch in EX)
//   * load-use hazard (one-cycle bubble)
//   * store split (a store issues as two halves over two cycles)
//
// Ports
//   clk                    rising-edge clock
//   rst                    asynchronous active-low reset
//   id_valid               decode slot holds a real instruction
//   id_opcode[4:0]         decode-stage opcode
//   id_rs1/id_rs2[3:0]     decode source registers
//   id_rs1_used/_rs2_used  source register is actually read
//   ex_opcode[4:0]         opcode in the execute stage
//   ex_wreg_en             execute-stage register write enable
//   ex_wreg_loc[3:0]       execute-stage destination register
//   branch_con             taken conditional branch from EX
//   pc_we                  PC update enable
//   ifid_we                IF/ID register write enable
//   idex_nop               force NOP into ID/EX
//   rst_branch_flush       active-low flush to the execute stage
//   state[1:0]             RUN=0, STR2=1, FLUSH1=2, FLUSH2=3
//   stall_cnt[7:0]         saturating count of cycles with pc_we=0
module ex_issue_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_opcode,
  input  logic       ex_wreg_en,
  input  logic [3:0] ex_wreg_loc,
  input  logic       branch_con,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       idex_nop,
  output logic       rst_branch_flush,
  output logic [1:0] state,
  output logic [7:0] stall_cnt
);

  localparam logic [4:0] OP_POP       = 5'd1;
  localparam logic [4:0] OP_LDR       = 5'd6;
  localparam logic [4:0] OP_STR       = 5'd7;
  localparam logic [4:0] OP_LDR_NOP   = 5'd8;
  localparam logic [4:0] OP_BRANCH_NC = 5'd10;
  localparam logic [4:0] OP_LDRB      = 5'd14;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STR2   = 2'd1,
    FLUSH1 = 2'd2,
    FLUSH2 = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  logic flush_req;
  logic ex_is_load;
  logic rs_match;
  logic load_use;

  assign flush_req  = branch_con | (ex_opcode == OP_BRANCH_NC);
  assign ex_is_load = (ex_opcode == OP_POP) | (ex_opcode == OP_LDR) |
                      (ex_opcode == OP_LDR_NOP) | (ex_opcode == OP_LDRB);
  assign rs_match   = (id_rs1_used & (id_rs1 == ex_wreg_loc)) |
                      (id_rs2_used & (id_rs2 == ex_wreg_loc));
  assign load_use   = ex_is_load & ex_wreg_en & id_valid & rs_match;

  always_comb begin
    pc_we            = 1'b1;
    ifid_we          = 1'b1;
    idex_nop         = 1'b0;
    rst_branch_flush = 1'b1;
    state_d          = state_q;

    unique case (state_q)
      RUN: begin
        if (flush_req) begin
          rst_branch_flush = 1'b0;
          idex_nop         = 1'b1;
          state_d          = FLUSH1;
        end else if (load_use) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_nop = 1'b1;
        end else if (id_valid && (id_opcode == OP_STR)) begin
          // first store half: hold fetch/decode so the same store re-issues
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          state_d = STR2;
        end
      end
      STR2: begin
        if (flush_req) begin
          rst_branch_flush = 1'b0;
          idex_nop         = 1'b1;
          state_d          = FLUSH1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH1: begin
        rst_branch_flush = 1'b0;
        idex_nop         = 1'b1;
        state_d          = FLUSH2;
      end
      FLUSH2: begin
        idex_nop = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase

    // reset overrides the combinational outputs immediately
    if (!rst) begin
      pc_we            = 1'b0;
      ifid_we          = 1'b0;
      idex_nop         = 1'b1;
      rst_branch_flush = 1'b0;
      state_d          = RUN;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
module tb_ex_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_opcode = 5'd16;
  logic [3:0] id_rs1 = '0, id_rs2 = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic [4:0] ex_opcode = 5'd16;
  logic       ex_wreg_en = 1'b0;
  logic [3:0] ex_wreg_loc = '0;
  logic       branch_con = 1'b0;
  logic       pc_we, ifid_we, idex_nop, rst_branch_flush;
  logic [1:0] state;
  logic [7:0] stall_cnt;

  ex_issue_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_opcode(ex_opcode), .ex_wreg_en(ex_wreg_en),
    .ex_wreg_loc(ex_wreg_loc), .branch_con(branch_con), .pc_we(pc_we),
    .ifid_we(ifid_we), .idex_nop(idex_nop), .rst_branch_flush(rst_branch_flush),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       nop;
    logic       rbf;
    logic [1:0] st;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what is still owed by earlier events.
  int flush_cycles_left = 0;  // 2 -> in first flush cycle, 1 -> second
  bit store_half_owed   = 0;
  int stalls            = 0;

  function automatic obs_t actual();
    obs_t a;
    a = '{pc: pc_we, ifid: ifid_we, nop: idex_nop, rbf: rst_branch_flush,
          st: state, cnt: stall_cnt};
    return a;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%b ifid=%b nop=%b rbf=%b st=%0d cnt=%0d, want pc=%b ifid=%b nop=%b rbf=%b st=%0d cnt=%0d",
               name, act.pc, act.ifid, act.nop, act.rbf, act.st, act.cnt,
               exp.pc, exp.ifid, exp.nop, exp.rbf, exp.st, exp.cnt);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("cycle", actual(), e);
    end
  end

  // Drive one cycle of inputs and push the model's prediction for it.
  task automatic cyc(input bit v, input logic [4:0] op, input logic [3:0] r1,
                     input logic [3:0] r2, input bit u1, input bit u2,
                     input logic [4:0] eop, input bit wen, input logic [3:0] wl,
                     input bit bc);
    obs_t e;
    bit   flush, lu;
    @(posedge clk);
    #1;
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2;
    id_rs1_used = u1; id_rs2_used = u2; ex_opcode = eop;
    ex_wreg_en = wen; ex_wreg_loc = wl; branch_con = bc;

    flush = bc || (eop == 5'd10);
    lu = (eop inside {5'd1, 5'd6, 5'd8, 5'd14}) && wen && v &&
         ((u1 && r1 == wl) || (u2 && r2 == wl));
    e.cnt = 8'(stalls);
    e.pc = 1; e.ifid = 1; e.nop = 0; e.rbf = 1; e.st = 2'd0;
    if (flush_cycles_left == 2) begin
      e.rbf = 0; e.nop = 1; e.st = 2'd2; flush_cycles_left = 1;
    end else if (flush_cycles_left == 1) begin
      e.nop = 1; e.st = 2'd3; flush_cycles_left = 0;
    end else if (flush) begin
      e.rbf = 0; e.nop = 1; e.st = store_half_owed ? 2'd1 : 2'd0;
      flush_cycles_left = 2; store_half_owed = 0;
    end else if (store_half_owed) begin
      e.st = 2'd1; store_half_owed = 0;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.nop = 1;
    end else if (v && op == 5'd7) begin
      e.pc = 0; e.ifid = 0; store_half_owed = 1;
    end
    if (!e.pc && stalls < 255) stalls++;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 5'd16, 0, 0, 0, 0, 5'd16, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t rexp;
    rexp = '{pc: 0, ifid: 0, nop: 1, rbf: 0, st: 2'd0, cnt: 8'd0};
    #2;
    check("reset_state", actual(), rexp);
    #21 rst = 1'b1;

    // load-use: ldr r3 in EX, decode reads r3
    cyc(1, 5'd0, 4'd3, 4'd0, 1, 0, 5'd6, 1, 4'd3, 0);
    idle();
    // load-use through rs2 with ldrb, then a non-load producer (no stall)
    cyc(1, 5'd0, 4'd1, 4'd9, 0, 1, 5'd14, 1, 4'd9, 0);
    cyc(1, 5'd0, 4'd9, 4'd0, 1, 0, 5'd3, 1, 4'd9, 0);
    // store split
    cyc(1, 5'd7, 4'd2, 4'd4, 1, 1, 5'd16, 0, 4'd0, 0);
    cyc(1, 5'd7, 4'd2, 4'd4, 1, 1, 5'd16, 0, 4'd0, 0);
    idle();
    // taken branch flush, branch_con ignored during flush cycles
    cyc(0, 5'd16, 0, 0, 0, 0, 5'd12, 0, 0, 1);
    cyc(1, 5'd0, 4'd3, 4'd0, 1, 0, 5'd6, 1, 4'd3, 1);
    cyc(0, 5'd16, 0, 0, 0, 0, 5'd10, 0, 0, 1);
    idle();
    // store split aborted by unconditional branch in STR2
    cyc(1, 5'd7, 0, 0, 0, 0, 5'd16, 0, 0, 0);
    cyc(1, 5'd7, 0, 0, 0, 0, 5'd10, 0, 0, 0);
    idle(); idle(); idle();
    // flush beats a store in decode the same cycle
    cyc(1, 5'd7, 0, 0, 0, 0, 5'd16, 0, 0, 1);
    idle(); idle(); idle();
    // saturation: hold load-use for 300 cycles
    for (int i = 0; i < 300; i++) cyc(1, 5'd0, 4'd5, 4'd0, 1, 0, 5'd1, 1, 4'd5, 0);
    idle();

    // randomized traffic; small register range so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] op, eop;
      op  = ($urandom_range(0, 3) == 0) ? 5'd7 : 5'($urandom_range(0, 16));
      case ($urandom_range(0, 7))
        0:       eop = 5'd10;
        1, 2:    eop = 5'd6;
        3:       eop = 5'd1;
        4:       eop = 5'd14;
        5:       eop = 5'd8;
        default: eop = 5'($urandom_range(0, 16));
      endcase
      cyc(1'($urandom_range(0, 3) != 0), op, 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), eop,
          1'($urandom), 4'($urandom_range(0, 3)),
          $urandom_range(0, 11) == 0);
    end
    idle(); idle(); idle();

    // asynchronous reset while in FLUSH1
    cyc(0, 5'd16, 0, 0, 0, 0, 5'd16, 0, 0, 1);
    @(posedge clk);
    #1;
    branch_con = 0; id_valid = 0; ex_opcode = 5'd16; ex_wreg_en = 0;
    #1 rst = 1'b0;
    #1 check("async_reset_flush1", actual(), rexp);
    exp_q.delete();
    flush_cycles_left = 0; store_half_owed = 0; stalls = 0;
    @(posedge clk); #1;
    check("reset_held", actual(), rexp);
    @(negedge clk); rst = 1'b1;
    idle();
    cyc(1, 5'd7, 0, 0, 0, 0, 5'd16, 0, 0, 0);
    idle(); idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
EX_ISSUE_CTRL -- requirements
Module: ex_issue_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_opcode  in  5  decode-stage opcode: push=0, pop=1, cmp=3, ldr=6, str=7, ldr_nop=8, branch_nc=10, branch_c=12, ldrb=14, NOP=16.
REQ-006 id_rs1, id_rs2  in  4 each  decode source registers.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  source is actually read.
REQ-008 ex_opcode  in  5  opcode currently in the execute stage.
REQ-009 ex_wreg_en, ex_wreg_loc  in  1/4  execute-stage write enable and destination.
REQ-010 branch_con  in  1  taken conditional branch, from the execute stage.
REQ-011 pc_we  out  1  PC update enable.
REQ-012 ifid_we  out  1  IF/ID register write enable.
REQ-013 idex_nop  out  1  forces NOP (16) into ID/EX.
REQ-014 rst_branch_flush  out  1  active-low flush to the execute stage.
REQ-015 state  out  2  RUN=0, STR2=1, FLUSH1=2, FLUSH2=3.
REQ-016 stall_cnt  out  8  count of cycles with pc_we=0.

Function
REQ-017 state and stall_cnt SHALL be registered; all other outputs SHALL be combinational from state and inputs.
REQ-018 flush_req SHALL be (branch_con | ex_opcode==10), evaluated only in RUN and STR2.
REQ-019 load_use SHALL be ex_opcode in {1,6,8,14} & ex_wreg_en & id_valid & ((id_rs1_used & id_rs1==ex_wreg_loc) | (id_rs2_used & id_rs2==ex_wreg_loc)).
REQ-020 Priority SHALL be flush_req > load_use > str split.
REQ-021 RUN, no event: pc_we=1, ifid_we=1, idex_nop=0, rst_branch_flush=1; stay in RUN.
REQ-022 RUN with flush_req: rst_branch_flush=0, idex_nop=1, pc_we=1, ifid_we=1; next state FLUSH1.
REQ-023 RUN with load_use: pc_we=0, ifid_we=0, idex_nop=1 for exactly that cycle; stay in RUN. The bubble clears the hazard on the next cycle.
REQ-024 RUN with id_valid & id_opcode==7 and no higher-priority event: issue the first store half with pc_we=0, ifid_we=0, idex_nop=0; next state STR2.
REQ-025 STR2: re-issue the store with pc_we=1, ifid_we=1, idex_nop=0; next state RUN.
REQ-026 STR2 with flush_req: the REQ-022 outputs SHALL apply, the second half SHALL be aborted, and the next state SHALL be FLUSH1.
REQ-027 FLUSH1: rst_branch_flush=0, idex_nop=1, pc_we=1, ifid_we=1; next state FLUSH2.
REQ-028 FLUSH2: rst_branch_flush=1, idex_nop=1, pc_we=1, ifid_we=1; next state RUN.
REQ-029 branch_con and load_use SHALL be ignored in FLUSH1 and FLUSH2.
REQ-030 flush_req and an str in decode in the same cycle: flush SHALL win and the str SHALL NOT be split.
REQ-031 stall_cnt SHALL increment on every clock with pc_we=0 and saturate at 255 (no wrap).
REQ-032 The encodings 0-3 are the only states; no other state is reachable.

Reset
REQ-033 While rst=0: state=RUN, stall_cnt=0, pc_we=0, ifid_we=0, idex_nop=1, rst_branch_flush=0.
REQ-034 Reset asserted mid-STR2 or mid-FLUSH SHALL abort immediately (asynchronous).
REQ-035 After rst deasserts, the first edge SHALL evaluate from RUN.

Verification
REQ-036 ex_opcode=6, ex_wreg_en=1, ex_wreg_loc=3; id_rs1=3, id_rs1_used=1, id_valid=1 -> one cycle of pc_we=0, ifid_we=0, idex_nop=1; stall_cnt 0->1.
REQ-037 id_opcode=7 in RUN -> cycle N: pc_we=0, state->STR2; cycle N+1: pc_we=1, idex_nop=0, state->RUN; stall_cnt +1.
REQ-038 branch_con=1 in RUN -> rst_branch_flush=0 for 2 cycles, idex_nop=1 for 3 cycles, state sequence RUN,FLUSH1,FLUSH2,RUN.
REQ-039 In STR2, ex_opcode=10 -> second store half aborted, state->FLUSH1, stall_cnt unchanged in that cycle.
REQ-040 Hold load_use for 300 cycles -> stall_cnt=255 and stays at 255.
REQ-041 Drop rst to 0 while in FLUSH1 -> state=RUN, rst_branch_flush=0, stall_cnt=0 without waiting for a clock edge.
